// File: rtl/led_display_ctrl.sv
// led_display_ctrl: shares the bouncing LED bar between two requesters with
// round-robin arbitration, generates the bar's step enable from a
// programmable divider, and holds the bar all-on (lock) for a fixed number
// of steps at every handover so the change of owner is visible.
//
// Request/grant handshake: a requester holds req high for as long as it
// wants the bar; gnt (one-hot, registered) tells it when it owns the bar.
// The owner gives the bar back either with a single-cycle done pulse or by
// dropping req. The owner sees gnt fall on the following cycle. A requester
// that is not the owner has no effect on the bar through done or req.
// The FSM state is held in the plainly named register 'state'.
module led_display_ctrl #(
  parameter int DIV_WIDTH   = 26,
  parameter int DEFAULT_DIV = 25_000_000,
  parameter int FLASH_STEPS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           done,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic [1:0]           gnt,
  output logic                 step,
  output logic                 lock
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLASH = 2'd2;

  localparam int                   FW         = $clog2(FLASH_STEPS + 1);
  localparam logic [FW-1:0]        FLASH_LAST = FW'(FLASH_STEPS - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET  = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] cnt;
  logic                 tick;
  logic [1:0]           state;
  logic                 owner;
  logic                 last;
  logic [FW-1:0]        fcnt;
  logic                 pick;
  logic                 rel;

  // A load restarts the period, so the load cycle itself never ticks.
  assign tick = !div_load && (cnt == div_reg - DIV_WIDTH'(1));

  // Owner chosen in IDLE: the lone requester, or the one not served last.
  always_comb begin
    pick = ~last;
    if (req == 2'b01) pick = 1'b0;
    else if (req == 2'b10) pick = 1'b1;
  end

  // The owner lets go with a done pulse or by dropping its request.
  always_comb begin
    rel = done[owner] | ~req[owner];
  end

  // Divider: free-running counter with a reloadable period (0 means 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= DIV_RESET;
      cnt     <= '0;
    end else if (div_load) begin
      div_reg <= (div_value == '0) ? DIV_WIDTH'(1) : div_value;
      cnt     <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
  end

  // Ownership FSM with registered gnt/step/lock outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      fcnt  <= '0;
      gnt   <= 2'b00;
      step  <= 1'b0;
      lock  <= 1'b1;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= RUN;
            owner <= pick;
            last  <= pick;
            gnt   <= pick ? 2'b10 : 2'b01;
            lock  <= 1'b0;
          end
        end
        RUN: begin
          if (rel) begin
            // A tick coinciding with the release is swallowed here: no step
            // and it does not count toward the flash hold.
            state <= FLASH;
            fcnt  <= '0;
            gnt   <= 2'b00;
            lock  <= 1'b1;
          end else begin
            step <= tick;
          end
        end
        FLASH: begin
          if (tick) begin
            fcnt <= fcnt + FW'(1);
            if (fcnt == FLASH_LAST) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          lock  <= 1'b1;
        end
      endcase
    end
  end

endmodule
